// File: rtl/ram_arb2_pkg.sv
// Shared encodings and default widths for the two-requester RAM arbiter.
package ram_arb2_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  localparam int AW_DEF = 2;
  localparam int DW_DEF = 4;

endpackage

// File: rtl/ram_arb2_pick.sv
// Combinational 2-way picker: round-robin on ties, or fixed priority to
// requester 0 when RAM_ARB2_FIXED_PRIO_EN is defined.
module arb2_pick
  import ram_arb2_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  assign any = req0 | req1;

`ifdef RAM_ARB2_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign winner = req0 ? ID_REQ0 : ID_REQ1;
`else
  always_comb begin
    winner = ID_REQ0;
    if (req0 && req1) begin
      // Tie goes to whoever was not served most recently.
      winner = (last == ID_REQ0) ? ID_REQ1 : ID_REQ0;
    end else if (req1) begin
      winner = ID_REQ1;
    end
  end
`endif

endmodule

// File: rtl/ram_arb2.sv
// Two-requester arbiter/sequencer owning a small register-file RAM.
// Tie-break policy selectable with RAM_ARB2_FIXED_PRIO_EN (default round-robin).
module ram_arb2
  import ram_arb2_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          busy
);

  state_t        state, state_nx;
  logic          last;
  logic          id_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] mem [2**AW];

  logic          winner;
  logic          any;
  logic          latch;

  arb2_pick u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any) begin
          state_nx = ST_ACCESS;
          latch    = 1'b1;
        end
      end
      ST_ACCESS: begin
        busy     = 1'b1;
        gnt0     = (id_q == ID_REQ0);
        gnt1     = (id_q == ID_REQ1);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture at IDLE->ACCESS; the access itself commits at the end of ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= ID_REQ1;
      id_q    <= ID_REQ0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem     <= '{default: '0};
    end else begin
      if (latch) begin
        id_q    <= winner;
        we_q    <= (winner == ID_REQ1) ? we1    : we0;
        addr_q  <= (winner == ID_REQ1) ? addr1  : addr0;
        wdata_q <= (winner == ID_REQ1) ? wdata1 : wdata0;
      end
      rvalid0 <= (state == ST_ACCESS) && !we_q && (id_q == ID_REQ0);
      rvalid1 <= (state == ST_ACCESS) && !we_q && (id_q == ID_REQ1);
      if (state == ST_ACCESS) begin
        last <= id_q;
        if (we_q) begin
          mem[addr_q] <= wdata_q;
        end else begin
          rdata <= mem[addr_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arb2.sv
// Directed self-checking bench for ram_arb2 (honours RAM_ARB2_FIXED_PRIO_EN).
module tb_ram_arb2;

  localparam int AW = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  ram_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc;
    @(negedge clk);
  endtask

  // One complete access: request, observe grant cycle, drop req, observe next cycle.
  task automatic access(input logic who, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output logic [1:0] g,
                        output logic [1:0] rv, output logic [DW-1:0] rd);
    if (who) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    cyc;
    g = {gnt0, gnt1};
    req0 = 1'b0;
    req1 = 1'b0;
    cyc;
    rv = {rvalid0, rvalid1};
    rd = rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc;
    cyc;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, busy});
    end
    n_cmp++;
    if (rdata !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_rdata got %h want 0", rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_read0;
    logic [1:0] g, rv;
    logic [DW-1:0] rd;
    access(1'b0, 1'b0, 2'd2, 4'h0, g, rv, rd);
    n_cmp++;
    if (g !== 2'b10) begin n_bad++; $display("FAIL read0_gnt got %b want 10", g); end
    n_cmp++;
    if (rv !== 2'b10) begin n_bad++; $display("FAIL read0_rvalid got %b want 10", rv); end
    n_cmp++;
    if (rd !== 4'h0) begin n_bad++; $display("FAIL read0_rdata got %h want 0", rd); end
    cyc;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL read0_pulse_end got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, busy});
    end
  endtask

  task automatic test_write_read;
    logic [1:0] g, rv;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 2'd1, 4'hA, g, rv, rd);
    n_cmp++;
    if (g !== 2'b10) begin n_bad++; $display("FAIL wr_gnt got %b want 10", g); end
    n_cmp++;
    if (rv !== 2'b00) begin n_bad++; $display("FAIL wr_rvalid got %b want 00", rv); end
    access(1'b1, 1'b0, 2'd1, 4'h0, g, rv, rd);
    n_cmp++;
    if (g !== 2'b01) begin n_bad++; $display("FAIL rd1_gnt got %b want 01", g); end
    n_cmp++;
    if (rv !== 2'b01) begin n_bad++; $display("FAIL rd1_rvalid got %b want 01", rv); end
    n_cmp++;
    if (rd !== 4'hA) begin n_bad++; $display("FAIL rd1_rdata got %h want a", rd); end
  endtask

  // mem[0]=0 and mem[1]=A here; both requesters read their own address.
  task automatic test_round_robin;
    logic [1:0] exp_g, prev_g;
    logic [DW-1:0] exp_d;
    prev_g = 2'b00;
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      cyc;
      if (i % 2 == 1) begin
`ifdef RAM_ARB2_FIXED_PRIO_EN
        exp_g = 2'b10;
`else
        exp_g = (i % 4 == 1) ? 2'b10 : 2'b01;
`endif
        n_cmp++;
        if ({gnt0, gnt1} !== exp_g) begin
          n_bad++;
          $display("FAIL rr_gnt cycle %0d got %b want %b", i, {gnt0, gnt1}, exp_g);
        end
        prev_g = exp_g;
      end else begin
        exp_d = prev_g[1] ? 4'h0 : 4'hA;
        n_cmp++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== {2'b00, prev_g}) begin
          n_bad++;
          $display("FAIL rr_idle cycle %0d got %b want 00%b", i,
                   {gnt0, gnt1, rvalid0, rvalid1}, prev_g);
        end
        n_cmp++;
        if (rdata !== exp_d) begin
          n_bad++;
          $display("FAIL rr_rdata cycle %0d got %h want %h", i, rdata, exp_d);
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    cyc;
  endtask

  task automatic test_rdata_hold;
    logic [1:0] g, rv;
    logic [DW-1:0] rd;
    access(1'b0, 1'b1, 2'd3, 4'h5, g, rv, rd);
    n_cmp++;
    if (g !== 2'b10) begin n_bad++; $display("FAIL hold_wr_gnt got %b want 10", g); end
    access(1'b0, 1'b0, 2'd3, 4'h0, g, rv, rd);
    n_cmp++;
    if ({rv, rd} !== {2'b10, 4'h5}) begin
      n_bad++;
      $display("FAIL hold_read got rv=%b rd=%h want rv=10 rd=5", rv, rd);
    end
    access(1'b0, 1'b1, 2'd3, 4'hC, g, rv, rd);
    n_cmp++;
    if ({rv, rd} !== {2'b00, 4'h5}) begin
      n_bad++;
      $display("FAIL hold_after_wr got rv=%b rd=%h want rv=00 rd=5", rv, rd);
    end
    cyc;
    n_cmp++;
    if (rdata !== 4'h5) begin n_bad++; $display("FAIL hold_later got %h want 5", rdata); end
  endtask

  task automatic test_reset_abort;
    logic [1:0] g, rv;
    logic [DW-1:0] rd;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 4'hF;
    cyc;
    n_cmp++;
    if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL abort_gnt got %b want 1", gnt0); end
    rst = 1'b1;
    req0 = 1'b0;
    cyc;
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, busy, rdata} !== 9'b0) begin
      n_bad++;
      $display("FAIL abort_state got %b want 0", {gnt0, gnt1, rvalid0, rvalid1, busy, rdata});
    end
    rst = 1'b0;
    // Tie right after reset: requester 0 wins under either policy.
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd1;
    cyc;
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_tie_gnt got %b want 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    cyc;
    n_cmp++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 4'h0}) begin
      n_bad++;
      $display("FAIL abort_read0 got rv=%b rd=%h want rv=10 rd=0", {rvalid0, rvalid1}, rdata);
    end
    access(1'b1, 1'b0, 2'd3, 4'h0, g, rv, rd);
    n_cmp++;
    if ({g, rv, rd} !== {2'b01, 2'b01, 4'h0}) begin
      n_bad++;
      $display("FAIL abort_mem_clear got g=%b rv=%b rd=%h want g=01 rv=01 rd=0", g, rv, rd);
    end
  endtask

  task automatic test_addr_change;
    logic [1:0] g, rv;
    logic [DW-1:0] rd;
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 4'h7;
    cyc;
    n_cmp++;
    if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL chg_gnt got %b want 1", gnt0); end
    addr0 = 2'd3;
    wdata0 = 4'h9;
    req0 = 1'b0;
    cyc;
    access(1'b0, 1'b0, 2'd2, 4'h0, g, rv, rd);
    n_cmp++;
    if ({rv, rd} !== {2'b10, 4'h7}) begin
      n_bad++;
      $display("FAIL chg_mem2 got rv=%b rd=%h want rv=10 rd=7", rv, rd);
    end
    access(1'b0, 1'b0, 2'd3, 4'h0, g, rv, rd);
    n_cmp++;
    if ({rv, rd} !== {2'b10, 4'h0}) begin
      n_bad++;
      $display("FAIL chg_mem3 got rv=%b rd=%h want rv=10 rd=0", rv, rd);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset;
    test_read0;
    test_write_read;
    test_round_robin;
    test_rdata_hold;
    test_reset_abort;
    test_addr_change;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
